// File: rtl/packet_pkg.sv
`default_nettype none
// ============================================================================
//  packet_pkg
//  Shared packet types, widths and header-check helpers for the switch egress.
//  Revision: 1.0
// ============================================================================
package packet_pkg;

    localparam int NUM_PORTS = 4;
    localparam int CNT_W     = 16;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        UNICAST   = 2'b00,
        MULTICAST = 2'b01,
        BROADCAST = 2'b10,
        RESERVED  = 2'b11
    } pkt_type_e;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } rx_state_e;

    function automatic logic [2:0] popcount4(input logic [NUM_PORTS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Destination must include us, source must be a single other port,
    // and the mask shape must match the packet type.
    function automatic logic hdr_legal(input logic [1:0]           port_id,
                                       input logic [NUM_PORTS-1:0] src,
                                       input logic [NUM_PORTS-1:0] tgt,
                                       input logic [1:0]           typ);
        logic [2:0] n_tgt;
        logic       ok;
        n_tgt = popcount4(tgt);
        ok    = tgt[port_id] && (popcount4(src) == 3'd1) && !src[port_id];
        case (pkt_type_e'(typ))
            UNICAST:   ok = ok && (n_tgt == 3'd1);
            MULTICAST: ok = ok && (n_tgt >= 3'd2) && (tgt != {NUM_PORTS{1'b1}});
            BROADCAST: ok = ok && (tgt == {NUM_PORTS{1'b1}});
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_queue.sv
`default_nettype none
// ============================================================================
//  rx_queue
//  First-word-fall-through FIFO whose head word is held in a register.
//  Revision: 1.0
// ============================================================================
module rx_queue
    import packet_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] c_ptr_one     = PTR_W'(1);
    localparam logic [PTR_W:0]   c_count_one   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   c_count_depth = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_head;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_count_depth);
    assign empty  = (r_count == '0);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign count  = r_count;
    assign head   = r_head;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
            // Head comes straight from din when the queue is (or becomes) empty,
            // otherwise from the next stored entry after a pop.
            if (empty || (w_pop && (r_count == c_count_one))) begin
                if (w_push) begin
                    r_head <= din;
                end
            end else if (w_pop) begin
                r_head <= r_mem[r_rd_ptr + c_ptr_one];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/port_rx_endpoint.sv
`default_nettype none
// ============================================================================
//  port_rx_endpoint
//  Egress receiver: header check, receive queue, consumer handshake, stats.
//  Optional per-type / per-source counters when RX_STATS_EN is defined.
//  Revision: 1.0
// ============================================================================
module port_rx_endpoint
    import packet_pkg::*;
#(
    parameter int PORT_ID   = 0,
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [3:0]           source_in,
    input  logic [3:0]           target_in,
    input  logic [1:0]           type_in,
    input  logic [PAYLOAD_W-1:0] data_in,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [3:0]           rx_source,
    output logic [1:0]           rx_type,
    output logic [PAYLOAD_W-1:0] rx_data,
    output logic                 err_pulse,
    output logic                 ovf_pulse,
    input  logic                 stats_clr,
    output logic [15:0]          rx_cnt,
    output logic [15:0]          err_cnt,
    output logic [15:0]          drop_cnt
`ifdef RX_STATS_EN
    ,
    output logic [15:0]          type_cnt0,
    output logic [15:0]          type_cnt1,
    output logic [15:0]          type_cnt2,
    output logic [15:0]          type_cnt3,
    output logic [15:0]          src_cnt0,
    output logic [15:0]          src_cnt1,
    output logic [15:0]          src_cnt2,
    output logic [15:0]          src_cnt3
`endif
);

    localparam int                 c_q_w       = NUM_PORTS + 2 + PAYLOAD_W;
    localparam logic [1:0]         c_port      = 2'(PORT_ID);
    localparam logic [$clog2(DEPTH):0] c_count_one = ($clog2(DEPTH)+1)'(1);

    rx_state_e              r_state;
    logic                   r_err_pulse;
    logic                   r_ovf_pulse;
    logic [CNT_W-1:0]       r_rx_cnt;
    logic [CNT_W-1:0]       r_err_cnt;
    logic [CNT_W-1:0]       r_drop_cnt;

    logic                   w_legal;
    logic                   w_err;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic [c_q_w-1:0]       w_head;

    assign w_legal = valid_in && hdr_legal(c_port, source_in, target_in, type_in);
    assign w_err   = valid_in && !w_legal;
    assign w_pop   = (r_state == ST_HOLD) && rx_ready && !w_empty;
    // A full queue still accepts when the head leaves on the same edge.
    assign w_push  = w_legal && (!w_full || w_pop);
    assign w_drop  = w_legal && w_full && !w_pop;

    rx_queue #(
        .DEPTH (DEPTH),
        .WIDTH (c_q_w)
    ) u_rx_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({source_in, type_in, data_in}),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .head  (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_pop && !w_push && (w_count == c_count_one)) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
            r_ovf_pulse <= 1'b0;
            r_rx_cnt    <= '0;
            r_err_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_err_pulse <= w_err;
            r_ovf_pulse <= w_drop;
            if (stats_clr) begin
                r_rx_cnt   <= '0;
                r_err_cnt  <= '0;
                r_drop_cnt <= '0;
            end else begin
                if (w_push) r_rx_cnt   <= sat_inc(r_rx_cnt);
                if (w_err)  r_err_cnt  <= sat_inc(r_err_cnt);
                if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign rx_valid                     = (r_state == ST_HOLD);
    assign {rx_source, rx_type, rx_data} = w_head;
    assign err_pulse                    = r_err_pulse;
    assign ovf_pulse                    = r_ovf_pulse;
    assign rx_cnt                       = r_rx_cnt;
    assign err_cnt                      = r_err_cnt;
    assign drop_cnt                     = r_drop_cnt;

`ifdef RX_STATS_EN
    logic [CNT_W-1:0] r_type_cnt [NUM_PORTS];
    logic [CNT_W-1:0] r_src_cnt  [NUM_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_type_cnt[i] <= '0;
                r_src_cnt[i]  <= '0;
            end
        end else if (stats_clr) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_type_cnt[i] <= '0;
                r_src_cnt[i]  <= '0;
            end
        end else if (w_push) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (type_in == 2'(i)) r_type_cnt[i] <= sat_inc(r_type_cnt[i]);
                if (source_in[i])     r_src_cnt[i]  <= sat_inc(r_src_cnt[i]);
            end
        end
    end

    assign type_cnt0 = r_type_cnt[0];
    assign type_cnt1 = r_type_cnt[1];
    assign type_cnt2 = r_type_cnt[2];
    assign type_cnt3 = r_type_cnt[3];
    assign src_cnt0  = r_src_cnt[0];
    assign src_cnt1  = r_src_cnt[1];
    assign src_cnt2  = r_src_cnt[2];
    assign src_cnt3  = r_src_cnt[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_port_rx_endpoint.sv
`default_nettype none
// ============================================================================
//  tb_port_rx_endpoint
//  Directed and random stimulus against a queue-based reference model.
//  Revision: 1.0
// ============================================================================
module tb_port_rx_endpoint;

    localparam int P     = 2;
    localparam int DEPTH = 4;
    localparam int PW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [3:0]    source_in = '0;
    logic [3:0]    target_in = '0;
    logic [1:0]    type_in = '0;
    logic [PW-1:0] data_in = '0;
    logic          rx_ready = 1'b0;
    logic          stats_clr = 1'b0;
    logic          rx_valid;
    logic [3:0]    rx_source;
    logic [1:0]    rx_type;
    logic [PW-1:0] rx_data;
    logic          err_pulse;
    logic          ovf_pulse;
    logic [15:0]   rx_cnt;
    logic [15:0]   err_cnt;
    logic [15:0]   drop_cnt;

    port_rx_endpoint #(.PORT_ID(P), .DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .source_in (source_in),
        .target_in (target_in),
        .type_in   (type_in),
        .data_in   (data_in),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_source (rx_source),
        .rx_type   (rx_type),
        .rx_data   (rx_data),
        .err_pulse (err_pulse),
        .ovf_pulse (ovf_pulse),
        .stats_clr (stats_clr),
        .rx_cnt    (rx_cnt),
        .err_cnt   (err_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    src;
        logic [1:0]    typ;
        logic [PW-1:0] data;
    } pkt_t;

    pkt_t        mq[$];
    int unsigned m_rx, m_err, m_drop;
    bit          m_errp, m_ovfp;
    int          n_total = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_legal(input logic [3:0] s, input logic [3:0] t, input logic [1:0] ty);
        int ns = $countones(s);
        int nt = $countones(t);
        if (t[P] !== 1'b1) return 0;
        if (ns != 1 || s[P] === 1'b1) return 0;
        case (ty)
            2'd0:    return nt == 1;
            2'd1:    return nt >= 2 && t != 4'hF;
            2'd2:    return t == 4'hF;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned bump(input int unsigned v, input bit ev, input bit clr);
        if (clr) return 0;
        if (ev && v < 65535) return v + 1;
        return v;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_rx = 0; m_err = 0; m_drop = 0;
        m_errp = 0; m_ovfp = 0;
    endtask

    task automatic model_update();
        bit   full, pop, lg, push;
        pkt_t p;
        full = mq.size() >= DEPTH;
        pop  = (mq.size() > 0) && rx_ready;
        lg   = valid_in && ref_legal(source_in, target_in, type_in);
        push = lg && (!full || pop);
        if (pop) void'(mq.pop_front());
        if (push) begin
            p.src = source_in; p.typ = type_in; p.data = data_in;
            mq.push_back(p);
        end
        m_errp = valid_in && !lg;
        m_ovfp = lg && full && !pop;
        m_rx   = bump(m_rx, push, stats_clr);
        m_err  = bump(m_err, m_errp, stats_clr);
        m_drop = bump(m_drop, m_ovfp, stats_clr);
    endtask

    task automatic compare_all();
        check("rx_valid", {31'b0, rx_valid}, {31'b0, mq.size() > 0});
        if (mq.size() > 0) begin
            check("rx_data", {16'b0, rx_data}, {16'b0, mq[0].data});
            check("rx_source", {28'b0, rx_source}, {28'b0, mq[0].src});
            check("rx_type", {30'b0, rx_type}, {30'b0, mq[0].typ});
        end
        check("err_pulse", {31'b0, err_pulse}, {31'b0, m_errp});
        check("ovf_pulse", {31'b0, ovf_pulse}, {31'b0, m_ovfp});
        check("rx_cnt", {16'b0, rx_cnt}, m_rx);
        check("err_cnt", {16'b0, err_cnt}, m_err);
        check("drop_cnt", {16'b0, drop_cnt}, m_drop);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic send(input logic [3:0] s, input logic [3:0] t, input logic [1:0] ty, input logic [PW-1:0] d);
        valid_in = 1'b1; source_in = s; target_in = t; type_in = ty; data_in = d;
        step();
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_inputs();
        valid_in = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 4) != 0) source_in = 4'b0001 << $urandom_range(0, 3);
        else                           source_in = 4'($urandom);
        target_in = 4'($urandom);
        if ($urandom_range(0, 4) != 0) target_in[P] = 1'b1;
        type_in   = 2'($urandom);
        data_in   = PW'($urandom);
        rx_ready  = ($urandom_range(0, 1) == 1);
        stats_clr = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        model_clear();
        #12;
        check("rst_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_data", {16'b0, rx_data}, 32'd0);
        check("rst_source", {28'b0, rx_source}, 32'd0);
        check("rst_type", {30'b0, rx_type}, 32'd0);
        compare_all();
        #6 rst_n = 1'b1;

        // single unicast packet, visible the cycle after sampling
        send(4'b0001, 4'b0100, 2'b00, 16'hA5A5);
        check("t1_valid", {31'b0, rx_valid}, 32'd1);
        check("t1_data", {16'b0, rx_data}, 32'h0000A5A5);
        check("t1_cnt", {16'b0, rx_cnt}, 32'd1);
        rx_ready = 1'b1;
        idle(2);

        // illegal headers
        send(4'b0001, 4'hE, 2'b10, 16'h1111);
        send(4'b0100, 4'b0100, 2'b00, 16'h2222);
        check("t2_err_cnt", {16'b0, err_cnt}, 32'd2);
        check("t2_valid", {31'b0, rx_valid}, 32'd0);
        idle(1);

        // overflow with consumer stalled, then drain
        rx_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(4'b1000, 4'b0100, 2'b00, PW'(16'h100 + i));
        check("t3_drop_cnt", {16'b0, drop_cnt}, 32'd2);
        rx_ready = 1'b1;
        idle(5);

        // full queue with simultaneous pop accepts the new packet
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'b0010, 4'b0101, 2'b01, PW'(16'h200 + i));
        rx_ready = 1'b1;
        send(4'b0001, 4'hF, 2'b10, 16'h2FF0);
        check("t4_drop_cnt", {16'b0, drop_cnt}, 32'd2);
        idle(6);

        // reset while three packets are queued
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'b0001, 4'b0100, 2'b00, PW'(16'h300 + i));
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("t6_async_valid", {31'b0, rx_valid}, 32'd0);
        compare_all();
        #2 rst_n = 1'b1;
        send(4'b1000, 4'b0100, 2'b00, 16'h3333);
        check("t6_after_valid", {31'b0, rx_valid}, 32'd1);
        check("t6_after_data", {16'b0, rx_data}, 32'h00003333);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        valid_in = 1'b0; stats_clr = 1'b0; rx_ready = 1'b1;
        idle(6);

        // counter saturation, then clear winning over an accept
        valid_in = 1'b1; source_in = 4'b0001; target_in = 4'b0100; type_in = 2'b00;
        for (int i = 0; i < 65540; i++) begin
            data_in = PW'(i);
            step();
        end
        check("sat_rx_cnt", {16'b0, rx_cnt}, 32'h0000FFFF);
        stats_clr = 1'b1;
        step();
        check("clr_wins", {16'b0, rx_cnt}, 32'd0);
        stats_clr = 1'b0;
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/port_rx_endpoint.md
Name: port_rx_endpoint

Overview:
- Egress-side receiver for one 4-port switch output; the counterpart of the ingress path.
- Samples packets the switch emits on an output port, checks each packet's header against the packet-type rules and this endpoint's port id, and buffers accepted packets in a small queue.
- Hands buffered packets to a local consumer over a valid/ready handshake and keeps error and drop statistics.

Parameters:
- PORT_ID, 0, index (0-3) of the switch output this endpoint attaches to.
- DEPTH, 4, receive queue entries (power of two, >=2).
- PAYLOAD_W, 16, payload width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  switch output packet strobe, one cycle per packet, no backpressure.
- source_in  in  4  one-hot source port.
- target_in  in  4  target port mask.
- type_in  in  2  packet type: 00 unicast, 01 multicast, 10 broadcast, 11 reserved.
- data_in  in  PAYLOAD_W  payload.
- rx_valid  out  1  head packet available to consumer.
- rx_ready  in  1  consumer accepts head packet.
- rx_source  out  4  head packet source.
- rx_type  out  2  head packet type.
- rx_data  out  PAYLOAD_W  head packet payload.
- err_pulse  out  1  one-cycle pulse on a header-check failure.
- ovf_pulse  out  1  one-cycle pulse when a legal packet is dropped because the queue is full.
- stats_clr  in  1  synchronous clear of all counters.
- rx_cnt  out  16  accepted packets, saturating.
- err_cnt  out  16  header errors, saturating.
- drop_cnt  out  16  overflow drops, saturating.

Behaviour:
- Reset: all outputs 0; queue empty; pointers 0; FSM in EMPTY.
- Header check, combinational on the valid_in cycle; the packet is legal only if all hold:
  - target_in[PORT_ID]=1.
  - source_in is one-hot and source_in[PORT_ID]=0.
  - Type vs mask: unicast requires a one-hot target_in; multicast requires popcount>=2 and target_in!=4'hF; broadcast requires target_in=4'hF; reserved is always illegal.
- Illegal packet: not written to the queue, err_pulse=1 next cycle, err_cnt+1.
- Legal packet with the queue not full, or full but popped in the same cycle: written on that edge, rx_cnt+1.
- Legal packet with the queue full and no pop: dropped, ovf_pulse=1 next cycle, drop_cnt+1.
- Latency: packet sampled at edge N is visible on rx_valid/rx_* after edge N, i.e. in cycle N+1 when the queue was empty. The queue is first-word-fall-through with registered outputs.
- Output FSM:
  - EMPTY: rx_valid=0. Goes to HOLD on any write.
  - HOLD: rx_valid=1 and rx_* stable until rx_ready. On the handshake it goes to EMPTY if count was 1 with no simultaneous write; otherwise it stays in HOLD with the next entry.
- rx_ready while rx_valid=0 is ignored.
- Pointers wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits wide.
- Counters saturate at 16'hFFFF.
- stats_clr zeroes all counters. If an increment occurs in the same cycle, the counter ends at 0 (clear wins). stats_clr does not touch the queue.
- Reset asserted mid-operation: the queue is flushed immediately (async) and any partially presented packet is lost.

Optional Feature:
- Macro: RX_STATS_EN.
- Defined:
  - Adds four outputs type_cnt0..type_cnt3 (16 bits each, saturating), counting accepted packets per type_in value.
  - Adds four outputs src_cnt0..src_cnt3 counting accepted packets per source.
  - All are cleared by stats_clr and reset.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Goes into packet_pkg:
  - pkt_type_e enum (UNICAST, MULTICAST, BROADCAST, RESERVED).
  - NUM_PORTS=4.
  - function hdr_legal(port_id, src, tgt, typ).
  - CNT_W=16 and a saturating-increment function.
- One sub-module: rx_queue, a FWFT FIFO with push, pop, full, empty and count, instantiated once.

Test Plan:
- PORT_ID=2; one unicast packet, src=4'b0001, tgt=4'b0100, data=16'hA5A5 → rx_valid rises cycle N+1, rx_data=16'hA5A5, rx_cnt=1.
- Broadcast packet, tgt=4'hE, and unicast packet, tgt=4'b0100, src=4'b0100 → both rejected, two err_pulse, err_cnt=2, rx_valid stays 0.
- rx_ready=0; 6 legal packets back-to-back, DEPTH=4 → 4 queued, ovf_pulse on packets 5 and 6, drop_cnt=2; then drain → payloads returned in arrival order.
- Queue full, legal packet arrives in the same cycle rx_ready=1 → packet accepted, drop_cnt unchanged, count stays 4.
- Preload rx_cnt to 16'hFFFF, then 1 more packet → stays 16'hFFFF. Assert stats_clr in the same cycle as an accept → rx_cnt=0.
- rst_n pulsed low while the queue holds 3 packets → rx_valid=0 immediately; after release, the next packet appears with 1-cycle latency.
